// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and
// parks a returned instruction in a one-entry buffer while the pipeline stalls.
module fetch_unit #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable_pc,
  input  logic [2:0]        PCSrc,
  input  logic [WORD_W-1:0] br_addr,
  input  logic [WORD_W-1:0] jmp_addr,
  input  logic [WORD_W-1:0] jr_addr,
  input  logic [WORD_W-1:0] nxt_pc_EX_MEM,
  input  logic              halt,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  output logic [WORD_W-1:0] instr_IF,
  output logic [WORD_W-1:0] npc_IF,
  output logic              ihit_IF,
  output logic              halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [WORD_W-1:0] FOUR       = {{(WORD_W-3){1'b0}}, 3'd4};
  localparam logic [WORD_W-1:0] ALIGN_MASK = {{(WORD_W-2){1'b1}}, 2'b00};

  state_t            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [WORD_W-1:0] pc_plus4_s;
  logic [WORD_W-1:0] sel_pc_s;
  logic [WORD_W-1:0] next_pc_s;

  assign pc_plus4_s = pc_q + FOUR;

  // Next-PC select; undefined codes fall through to pc+4.
  always_comb begin
    sel_pc_s = pc_plus4_s;
    case (PCSrc)
      3'd0:    sel_pc_s = pc_plus4_s;
      3'd1:    sel_pc_s = br_addr;
      3'd2:    sel_pc_s = jmp_addr;
      3'd3:    sel_pc_s = jr_addr;
      3'd4:    sel_pc_s = nxt_pc_EX_MEM;
      default: sel_pc_s = pc_plus4_s;
    endcase
    next_pc_s = sel_pc_s & ALIGN_MASK;
  end

  // State transitions, PC update and buffer capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    case (state_q)
      FETCH: begin
        if (halt) begin
          state_d = HALTED;
        end else if (ihit && enable_pc) begin
          pc_d = next_pc_s;
        end else if (ihit) begin
          buf_d   = imemload;
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (halt) begin
          state_d = HALTED;
        end else if (enable_pc) begin
          pc_d    = next_pc_s;
          buf_d   = '0;
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      HALTED: state_d = HALTED;
      default: begin
        state_d = FETCH;
        buf_d   = '0;
      end
    endcase
  end

  // Outputs; reset suppresses the same-cycle ihit pass-through.
  always_comb begin
    imemREN  = 1'b0;
    ihit_IF  = 1'b0;
    instr_IF = '0;
    halted   = 1'b0;
    case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit && !RST) begin
          ihit_IF  = 1'b1;
          instr_IF = imemload;
        end else begin
          ihit_IF  = 1'b0;
        end
      end
      HOLD: begin
        ihit_IF  = 1'b1;
        instr_IF = buf_q;
      end
      HALTED: halted = 1'b1;
      default: imemREN = 1'b0;
    endcase
  end

  assign imemaddr = pc_q;
  assign npc_IF   = pc_plus4_s;

  // Architectural state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, redirects, stall buffer,
// wrap-around, halt and asynchronous reset.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        enable_pc, enable_pc2;
  logic [2:0]  PCSrc;
  logic [31:0] br_addr, jmp_addr, jr_addr, nxt_pc_EX_MEM;
  logic        halt;
  logic        ihit, ihit2;
  logic [31:0] imemload;

  logic        imemREN, ihit_IF, halted;
  logic [31:0] imemaddr, instr_IF, npc_IF;
  logic        imemREN2, ihit_IF2, halted2;
  logic [31:0] imemaddr2, instr_IF2, npc_IF2;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .enable_pc(enable_pc), .PCSrc(PCSrc),
    .br_addr(br_addr), .jmp_addr(jmp_addr), .jr_addr(jr_addr),
    .nxt_pc_EX_MEM(nxt_pc_EX_MEM), .halt(halt), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .instr_IF(instr_IF), .npc_IF(npc_IF),
    .ihit_IF(ihit_IF), .halted(halted)
  );

  fetch_unit #(.PC_INIT(32'hFFFF_FFF8)) dut_wrap (
    .CLK(CLK), .RST(RST), .enable_pc(enable_pc2), .PCSrc(PCSrc),
    .br_addr(br_addr), .jmp_addr(jmp_addr), .jr_addr(jr_addr),
    .nxt_pc_EX_MEM(nxt_pc_EX_MEM), .halt(halt), .ihit(ihit2), .imemload(imemload),
    .imemREN(imemREN2), .imemaddr(imemaddr2), .instr_IF(instr_IF2), .npc_IF(npc_IF2),
    .ihit_IF(ihit_IF2), .halted(halted2)
  );

  task automatic test_reset();
    RST = 1'b1; enable_pc = 1'b1; enable_pc2 = 1'b0; PCSrc = 3'd0;
    br_addr = 32'h0; jmp_addr = 32'h0; jr_addr = 32'h0; nxt_pc_EX_MEM = 32'h0;
    halt = 1'b0; ihit = 1'b1; ihit2 = 1'b0; imemload = 32'hCAFE_0001;
    #2;
    total++; if (imemREN !== 1'b1) begin bad++; $display("FAIL reset_ren got %b exp 1", imemREN); end
    total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL reset_addr got %h exp 00000000", imemaddr); end
    total++; if (ihit_IF !== 1'b0) begin bad++; $display("FAIL reset_ihit got %b exp 0", ihit_IF); end
    total++; if (instr_IF !== 32'h0) begin bad++; $display("FAIL reset_instr got %h exp 00000000", instr_IF); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got %b exp 0", halted); end
    total++; if (npc_IF !== 32'h4) begin bad++; $display("FAIL reset_npc got %h exp 00000004", npc_IF); end
    total++; if (imemaddr2 !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_addr2 got %h exp fffffff8", imemaddr2); end
    @(posedge CLK); #1;
    total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL reset_hold_addr got %h exp 00000000", imemaddr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    @(negedge CLK); RST = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (imemaddr !== exp_pc) begin bad++; $display("FAIL seq_addr%0d got %h exp %h", i, imemaddr, exp_pc); end
      total++; if (npc_IF !== exp_pc + 32'd4) begin bad++; $display("FAIL seq_npc%0d got %h exp %h", i, npc_IF, exp_pc + 32'd4); end
      total++; if (ihit_IF !== 1'b1) begin bad++; $display("FAIL seq_ihit%0d got %b exp 1", i, ihit_IF); end
      total++; if (instr_IF !== 32'hCAFE_0001) begin bad++; $display("FAIL seq_instr%0d got %h exp cafe0001", i, instr_IF); end
      @(posedge CLK); #1;
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect();
    logic [2:0]  src [5]  = '{3'd1, 3'd4, 3'd3, 3'd2, 3'd6};
    logic [31:0] want [5] = '{32'h40, 32'h14, 32'h20, 32'h100, 32'h104};
    br_addr = 32'h40; nxt_pc_EX_MEM = 32'h14; jr_addr = 32'h23; jmp_addr = 32'h100;
    total++; if (imemaddr !== 32'h10) begin bad++; $display("FAIL redir_start got %h exp 00000010", imemaddr); end
    for (int i = 0; i < 5; i++) begin
      PCSrc = src[i];
      @(posedge CLK); #1;
      total++; if (imemaddr !== want[i]) begin bad++; $display("FAIL redir_src%0d got %h exp %h", src[i], imemaddr, want[i]); end
    end
    PCSrc = 3'd0;
  endtask

  task automatic test_hold();
    enable_pc = 1'b0; imemload = 32'h8C22_0004; #1;
    total++; if (instr_IF !== 32'h8C22_0004 || imemREN !== 1'b1) begin bad++; $display("FAIL hold_capture got %h/%b exp 8c220004/1", instr_IF, imemREN); end
    @(posedge CLK); #1;
    ihit = 1'b0; imemload = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (imemREN !== 1'b0) begin bad++; $display("FAIL hold_ren%0d got %b exp 0", i, imemREN); end
      total++; if (instr_IF !== 32'h8C22_0004 || ihit_IF !== 1'b1) begin bad++; $display("FAIL hold_instr%0d got %h/%b exp 8c220004/1", i, instr_IF, ihit_IF); end
      total++; if (imemaddr !== 32'h104) begin bad++; $display("FAIL hold_addr%0d got %h exp 00000104", i, imemaddr); end
      @(posedge CLK); #1;
    end
    enable_pc = 1'b1;
    @(posedge CLK); #1;
    total++; if (imemaddr !== 32'h108 || imemREN !== 1'b1) begin bad++; $display("FAIL hold_release got %h/%b exp 00000108/1", imemaddr, imemREN); end
    total++; if (ihit_IF !== 1'b0 || instr_IF !== 32'h0) begin bad++; $display("FAIL hold_release_out got %b/%h exp 0/00000000", ihit_IF, instr_IF); end
  endtask

  task automatic test_halt();
    ihit = 1'b1; PCSrc = 3'd2; jmp_addr = 32'h30;
    @(posedge CLK); #1;
    PCSrc = 3'd0; halt = 1'b1;
    total++; if (imemaddr !== 32'h30) begin bad++; $display("FAIL halt_pre got %h exp 00000030", imemaddr); end
    @(posedge CLK); #1;
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enable_pc = (i != 1);
      #1;
      total++; if (halted !== 1'b1 || imemREN !== 1'b0) begin bad++; $display("FAIL halt_state%0d got %b/%b exp 1/0", i, halted, imemREN); end
      total++; if (imemaddr !== 32'h30) begin bad++; $display("FAIL halt_addr%0d got %h exp 00000030", i, imemaddr); end
      total++; if (ihit_IF !== 1'b0 || instr_IF !== 32'h0) begin bad++; $display("FAIL halt_out%0d got %b/%h exp 0/00000000", i, ihit_IF, instr_IF); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_async_reset();
    RST = 1'b1; #1;
    total++; if (halted !== 1'b0 || imemaddr !== 32'h0) begin bad++; $display("FAIL rst_from_halt got %b/%h exp 0/00000000", halted, imemaddr); end
    @(negedge CLK); RST = 1'b0; ihit = 1'b1; enable_pc = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    enable_pc = 1'b0; imemload = 32'h1111_2222;
    @(posedge CLK); #1;
    total++; if (imemREN !== 1'b0 || imemaddr !== 32'h8) begin bad++; $display("FAIL rst_pre_hold got %b/%h exp 0/00000008", imemREN, imemaddr); end
    #2; RST = 1'b1; #1;
    total++; if (imemaddr !== 32'h0 || imemREN !== 1'b1) begin bad++; $display("FAIL rst_async got %h/%b exp 00000000/1", imemaddr, imemREN); end
    total++; if (ihit_IF !== 1'b0) begin bad++; $display("FAIL rst_async_ihit got %b exp 0", ihit_IF); end
    ihit = 1'b0;
    @(negedge CLK); RST = 1'b0; #1;
    total++; if (ihit_IF !== 1'b0 || instr_IF !== 32'h0) begin bad++; $display("FAIL rst_buf_gone got %b/%h exp 0/00000000", ihit_IF, instr_IF); end
    @(posedge CLK); #1;
    total++; if (ihit_IF !== 1'b0 || imemREN !== 1'b1 || imemaddr !== 32'h0) begin bad++; $display("FAIL rst_after got %b/%b/%h exp 0/1/00000000", ihit_IF, imemREN, imemaddr); end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    ihit2 = 1'b1; enable_pc2 = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (imemaddr2 !== want[i]) begin bad++; $display("FAIL wrap_addr%0d got %h exp %h", i, imemaddr2, want[i]); end
      total++; if (npc_IF2 !== want[i] + 32'd4) begin bad++; $display("FAIL wrap_npc%0d got %h exp %h", i, npc_IF2, want[i] + 32'd4); end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_hold();
    test_halt();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
